// File: rtl/add3_accum_seq.sv
// Burst accumulator front-end: feeds an external combinational 3-input adder
// two buffered words per ADD step and keeps a wrapping sum plus sticky carry.
module add3_accum_seq #(
  parameter int W     = 6,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_ovf,
  output logic             busy,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic [W-1:0]     add_c,
  input  logic [W-1:0]     add_sum,
  input  logic             add_carry
);

  typedef enum logic [2:0] {IDLE, GET_B, GET_C, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     bufb_q, bufb_d;
  logic [W-1:0]     bufc_q, bufc_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      bufb_q  <= '0;
      bufc_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bufb_q  <= bufb_d;
      bufc_q  <= bufc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bufb_d  = bufb_q;
    bufc_d  = bufc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          bufb_d  = '0;
          bufc_d  = '0;
          state_d = (len != '0) ? GET_B : DONE;
        end
      end
      GET_B: begin
        if (in_valid) begin
          bufb_d = in_data;
          rem_d  = rem_q - LEN_W'(1);
          // Last word of an odd burst is added with a zero C operand
          if (rem_q == LEN_W'(1)) begin
            bufc_d  = '0;
            state_d = ADD;
          end else begin
            state_d = GET_C;
          end
        end
      end
      GET_C: begin
        if (in_valid) begin
          bufc_d  = in_data;
          rem_d   = rem_q - LEN_W'(1);
          state_d = ADD;
        end
      end
      ADD: begin
        acc_d = add_sum;
        ovf_d = ovf_q | add_carry;
        if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          bufb_d  = '0;
          bufc_d  = '0;
          state_d = GET_B;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == GET_B) || (state_q == GET_C);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign add_a     = acc_q;
  assign add_b     = bufb_q;
  assign add_c     = bufc_q;

endmodule

// File: tb/tb_add3_accum_seq.sv
// Directed bench for add3_accum_seq with a behavioural 6-bit 3-input adder.
module tb_add3_accum_seq;
  localparam int W     = 6;
  localparam int LEN_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic             out_ovf;
  logic             busy;
  logic [W-1:0]     add_a, add_b, add_c;
  logic [W-1:0]     add_sum;
  logic             add_carry;
  logic [7:0]       tot;

  add3_accum_seq #(.W(W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .add_sum(add_sum), .add_carry(add_carry)
  );

  // External adder model
  assign tot       = 8'(add_a) + 8'(add_b) + 8'(add_c);
  assign add_sum   = tot[W-1:0];
  assign add_carry = (tot >= 8'd64);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wq[$];
  int rdy_log[64];
  int busy_log[64];
  int adda_log[64];
  int addc_log[64];
  int lat;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic log_cycle(input int n);
    rdy_log[n]  = int'(in_ready);
    busy_log[n] = int'(busy);
    adda_log[n] = int'(add_a);
    addc_log[n] = int'(add_c);
  endtask

  // Start a burst from wq and feed it until out_valid; lat = edges from start
  task automatic do_burst(input int l, input bit stress, output int latency);
    int  n;
    int  idx;
    bit  hs;
    start = 1'b1;
    len   = LEN_W'(l);
    tick();
    start = 1'b0;
    n     = 1;
    idx   = 0;
    log_cycle(n);
    while (!out_valid && n < 60) begin
      if (stress && n == 3) begin
        start = 1'b1;
        len   = LEN_W'(2);
      end else begin
        start = 1'b0;
      end
      in_valid = (idx < l) && (!stress || ($urandom_range(0, 2) != 0));
      in_data  = (idx < l) ? W'(wq[idx]) : '0;
      hs       = in_valid && in_ready;
      tick();
      n++;
      if (hs) idx++;
      log_cycle(n);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (!out_valid) chk("timeout_out_valid", int'(out_valid), 1);
    latency = n;
  endtask

  task automatic finish_burst(input int hold, input int exp_sum, input int exp_ovf);
    chk("done_sum", int'(out_sum), exp_sum);
    chk("done_ovf", int'(out_ovf), exp_ovf);
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      tick();
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_sum", int'(out_sum), exp_sum);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_valid", int'(out_valid), 0);
    chk("post_busy", int'(busy), 0);
    chk("post_sum", int'(out_sum), exp_sum);
    chk("post_ovf", int'(out_ovf), exp_ovf);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_sum"}, int'(out_sum), 0);
    chk({tag, "_out_ovf"}, int'(out_ovf), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_add_a"}, int'(add_a), 0);
    chk({tag, "_add_b"}, int'(add_b), 0);
    chk({tag, "_add_c"}, int'(add_c), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // len=4, back-to-back words
    wq = '{3, 5, 7, 9};
    do_burst(4, 1'b0, lat);
    chk("len4_latency", lat, 7);
    for (int n = 1; n <= 6; n++) chk("len4_busy", busy_log[n], 1);
    chk("len4_rdy_getb", rdy_log[1], 1);
    chk("len4_rdy_add1", rdy_log[3], 0);
    chk("len4_rdy_add2", rdy_log[6], 0);
    finish_burst(0, 24, 0);

    // odd length: second ADD sees A=30, C=0
    wq = '{10, 20, 30};
    do_burst(3, 1'b0, lat);
    chk("len3_latency", lat, 6);
    chk("len3_add_a", adda_log[5], 30);
    chk("len3_add_c", addc_log[5], 0);
    finish_burst(0, 60, 0);

    // 40+40 wraps to 16 with carry
    wq = '{40, 40};
    do_burst(2, 1'b0, lat);
    chk("ovf_latency", lat, 4);
    finish_burst(0, 16, 1);

    // sticky overflow clears on a new start
    wq = '{5};
    do_burst(1, 1'b0, lat);
    chk("len1_latency", lat, 3);
    finish_burst(0, 5, 0);

    // zero-length burst
    wq = '{};
    do_burst(0, 1'b0, lat);
    chk("len0_latency", lat, 1);
    chk("len0_rdy", rdy_log[1], 0);
    finish_burst(0, 0, 0);

    // random in_valid gaps, ignored mid-burst start, held output
    wq = '{1, 2, 3, 4};
    do_burst(4, 1'b1, lat);
    finish_burst(5, 10, 0);

    // reset mid-burst after two words of a len=6 burst
    start = 1'b1;
    len   = LEN_W'(6);
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = W'(1);
    tick();
    in_data = W'(2);
    tick();
    in_valid = 1'b0;
    chk("pre_reset_add_b", int'(add_b), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_outputs("midrst");

    wq = '{1, 1};
    do_burst(2, 1'b0, lat);
    chk("after_rst_latency", lat, 4);
    finish_burst(0, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
